// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-addressed data-memory interface.
// Byte-addressed requests are split into a word index and a little-endian byte lane.
// Loads are extended to 32 bits.
// Byte and halfword stores are done as read-modify-write.
module load_store_unit #(
  parameter int unsigned DEPTH = 206
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RMW  = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      addr_lo_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [DW-1:0]   wdata_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [DW-1:0]   resp_rdata_q;
  logic [DW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_din_q;
  logic            mem_we_q;

  logic [4:0]      byte_sh;
  logic [4:0]      half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [DW-1:0]   load_ext;
  logic [DW-1:0]   merged;
  logic            acc_err;

  // Lane extraction, load extension, store merge and request legality check.
  always_comb begin
    byte_sh  = {addr_lo_q, 3'b000};
    half_sh  = {addr_lo_q[1], 4'b0000};
    byte_v   = 8'(mem_dout >> byte_sh);
    half_v   = 16'(mem_dout >> half_sh);
    load_ext = mem_dout;
    merged   = mem_dout;
    acc_err  = 1'b0;

    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_ext = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = mem_dout;
    endcase

    if (size_q == SZ_BYTE) begin
      merged = (mem_dout & ~(32'h0000_00FF << byte_sh)) | (DW'(wdata_q[7:0]) << byte_sh);
    end else begin
      merged = (mem_dout & ~(32'h0000_FFFF << half_sh)) | (DW'(wdata_q[15:0]) << half_sh);
    end

    if (req_size == SZ_ILL)                                  acc_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])                  acc_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)       acc_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= DW'(DEPTH))               acc_err = 1'b1;
  end

  // Control FSM with registered memory-side and response-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_lo_q   <= req_addr[1:0];
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            mem_addr_q  <= {2'b00, req_addr[31:2]};
            req_ready_q <= 1'b0;
            if (acc_err) begin
              state_q <= S_ERR;
            end else if (!req_we) begin
              state_q <= S_RD;
            end else if (req_size == SZ_WORD) begin
              mem_din_q <= req_wdata;
              mem_we_q  <= 1'b1;
              state_q   <= S_WR;
            end else begin
              state_q <= S_RMW;
            end
          end
        end
        S_RD: begin
          resp_rdata_q <= load_ext;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_RMW: begin
          mem_din_q <= merged;
          mem_we_q  <= 1'b1;
          state_q   <= S_WR;
        end
        S_WR: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        S_ERR: begin
          resp_rdata_q <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, a directed vector table and a reset-during-RMW sequence.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 206;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:DEPTH-1];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_dat;

  int n_total = 0;
  int n_pass  = 0;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: write at posedge, read data refreshed at negedge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
    end else if (mem_we && mem_addr < DEPTH) begin
      mem[mem_addr[7:0]] <= mem_din;
    end
    if (bd_we) mem[bd_idx] <= bd_dat;
  end

  always @(negedge clk) begin
    mem_dout <= (mem_addr < DEPTH) ? mem[mem_addr[7:0]] : 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          wek;
    logic [31:0] wea;
  } vec_t;

  vec_t tbl[16];

  // Issue one request and measure response timing, data and memory writes.
  task automatic run(input vec_t v);
    int          lat = 99;
    int          wek = -1;
    int          wec = 0;
    logic [31:0] wea = 32'h0;
    logic [31:0] rd  = 32'h0;
    logic        er  = 1'b0;
    logic        rdy0 = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) rdy0 = req_ready;
      if (mem_we) begin
        wec++;
        if (wek < 0) begin wek = k; wea = mem_addr; end
      end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; break; end
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " err"}, 32'(er), 32'(v.err));
    chk({v.name, " rdata"}, rd, v.rdata);
    chk({v.name, " ready_busy"}, 32'(rdy0), 32'h0);
    chk({v.name, " we_cycle"}, 32'(wek), 32'(v.wek));
    chk({v.name, " we_count"}, 32'(wec), (v.wek < 0) ? 32'h0 : 32'h1);
    if (v.wek >= 0) chk({v.name, " we_addr"}, wea, v.wea);
    @(negedge clk);
    chk({v.name, " resp_pulse"}, 32'(resp_valid), 32'h0);
    chk({v.name, " ready_after"}, 32'(req_ready), 32'h1);
  endtask

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] wd,
                              input int lat, input logic er, input logic [31:0] rd,
                              input int wek, input logic [31:0] wea);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
    v.lat = lat; v.err = er; v.rdata = rd; v.wek = wek; v.wea = wea;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk("lb_s_10",   0, 2'b00, 0, 32'h10,  32'h0,         1, 0, 32'hFFFF_FFF0, -1, 0);
    tbl[1]  = mk("lbu_13",    0, 2'b00, 1, 32'h13,  32'h0,         1, 0, 32'h0000_0082, -1, 0);
    tbl[2]  = mk("lh_s_12",   0, 2'b01, 0, 32'h12,  32'h0,         1, 0, 32'hFFFF_8234, -1, 0);
    tbl[3]  = mk("lw_10",     0, 2'b10, 1, 32'h10,  32'h0,         1, 0, 32'h8234_56F0, -1, 0);
    tbl[4]  = mk("sb_11",     1, 2'b00, 0, 32'h11,  32'h0000_00AB, 2, 0, 32'h0,         1, 32'h4);
    tbl[5]  = mk("lw_10_rmw", 0, 2'b10, 0, 32'h10,  32'h0,         1, 0, 32'h8234_ABF0, -1, 0);
    tbl[6]  = mk("sw_20",     1, 2'b10, 0, 32'h20,  32'hDEAD_BEEF, 1, 0, 32'h0,         0, 32'h8);
    tbl[7]  = mk("lw_20",     0, 2'b10, 0, 32'h20,  32'h0,         1, 0, 32'hDEAD_BEEF, -1, 0);
    tbl[8]  = mk("lw_mis_12", 0, 2'b10, 0, 32'h12,  32'h0,         1, 1, 32'h0,        -1, 0);
    tbl[9]  = mk("sh_mis_11", 1, 2'b01, 0, 32'h11,  32'h0000_1234, 1, 1, 32'h0,        -1, 0);
    tbl[10] = mk("size_11",   0, 2'b11, 0, 32'h10,  32'h0,         1, 1, 32'h0,        -1, 0);
    tbl[11] = mk("lw_oor",    0, 2'b10, 0, 32'h338, 32'h0,         1, 1, 32'h0,        -1, 0);
    tbl[12] = mk("lw_last",   0, 2'b10, 0, 32'h334, 32'h0,         1, 0, 32'h0,        -1, 0);
    tbl[13] = mk("sh_22",     1, 2'b01, 0, 32'h22,  32'h1234_CAFE, 2, 0, 32'h0,         1, 32'h8);
    tbl[14] = mk("lh_s_20",   0, 2'b01, 0, 32'h20,  32'h0,         1, 0, 32'hFFFF_BEEF, -1, 0);
    tbl[15] = mk("lb_s_23",   0, 2'b00, 0, 32'h23,  32'h0,         1, 0, 32'hFFFF_FFCA, -1, 0);

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_idx = 8'h0; bd_dat = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h1);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst resp_err", 32'(resp_err), 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    reset = 1'b0;
    bd_we = 1'b1; bd_idx = 8'd4; bd_dat = 32'h8234_56F0;
    @(posedge clk);
    #1 bd_we = 1'b0;

    for (int i = 0; i < 16; i++) run(tbl[i]);
    chk("mem4 final", mem[4], 32'h8234_ABF0);
    chk("mem8 final", mem[8], 32'hCAFE_BEEF);
    chk("mem5 untouched", mem[5], 32'h0);

    // Reset while the byte store sits in RMW: nothing written, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw busy ready", 32'(req_ready), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstrmw mem_we", 32'(mem_we), 32'h0);
    chk("rstrmw resp_valid", 32'(resp_valid), 32'h0);
    chk("rstrmw req_ready", 32'(req_ready), 32'h1);
    reset = 1'b0;
    begin
      int seen_we = 0;
      int seen_rv = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (mem_we) seen_we++;
        if (resp_valid) seen_rv++;
      end
      chk("rstrmw no write", 32'(seen_we), 32'h0);
      chk("rstrmw no resp", 32'(seen_rv), 32'h0);
    end
    // The memory model clears on reset; restore word 4 and confirm a clean load.
    bd_we = 1'b1; bd_idx = 8'd4; bd_dat = 32'h8234_ABF0;
    @(posedge clk);
    #1 bd_we = 1'b0;
    run(mk("lb_after_rst", 0, 2'b00, 0, 32'h11, 32'h0, 1, 0, 32'hFFFF_FFAB, -1, 0));
    chk("mem4 after rst", mem[4], 32'h8234_ABF0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface.
- Accepts byte-addressed load/store requests from the execute stage.
- Converts each request to a word index and drives the word-addressed data memory: address, write data and write enable.
- Returns load data with sign/zero extension; performs read-modify-write for byte and halfword stores.
- Little-endian byte lanes.

Parameters:
- DEPTH, 206: number of 32-bit words in the attached data memory; word indices >= DEPTH are out of range.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid; request rejected.
- resp_rdata  output  32  load result; 0 for stores and errors.
- mem_addr  output  32  word index to memory (req_addr >> 2).
- mem_din  output  32  write data to memory.
- mem_we  output  1  memory write enable.
- mem_dout  input  32  memory read data; updated on negedge clk from mem_addr.

Behaviour:
- Reset (sync, posedge with reset=1) puts the unit in IDLE with all outputs at 0 except req_ready=1.
  - Applies in any state; an in-flight operation is abandoned.
  - mem_we is 0 after that edge; no resp_valid is produced for the abandoned request.
- All mem_* outputs and resp_* outputs are registered. mem_we must never glitch within a cycle.
- mem_addr holds its last value in IDLE. mem_we is 1 only in state WR.
- States and transitions:
  - IDLE: req_ready=1. Accept when req_valid=1 at posedge E0 and latch all req_* fields.
    - Error check: size 11, half with addr[0]=1, word with addr[1:0]!=0, or (addr>>2) >= DEPTH → ERR.
    - Otherwise: load → RD; word store → WR with mem_din=wdata and mem_we=1; byte/half store → RMW.
    - mem_addr is loaded at E0.
  - RD: one cycle. At E1, capture mem_dout, extract the lane, extend to 32 bits into resp_rdata, set resp_valid=1, go to IDLE.
  - RMW: one cycle. At E1, merge wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1], of mem_dout. Result goes to mem_din; set mem_we=1; go to WR.
  - WR: one cycle. Memory writes at the next posedge. At that edge mem_we=0, resp_valid=1, resp_rdata=0, go to IDLE.
  - ERR: one cycle. At E1, resp_valid=1, resp_err=1, resp_rdata=0, go to IDLE. No memory write ever occurs for an errored request.
- Latency, counted from the acceptance edge E0:
  - Load: resp_valid high after E1.
  - Word store: resp_valid high after E1; memory updated at E1.
  - Sub-word store: resp_valid high after E2.
  - Error: resp_valid high after E1.
- resp_valid is high exactly one cycle per accepted request. The next request is accepted no earlier than the edge following resp_valid assertion.
- req_valid while req_ready=0 is ignored, not queued.
- Lane extraction:
  - byte = mem_dout[8*addr[1:0] +: 8]
  - half = mem_dout[16*addr[1] +: 16]
  - Sign extension uses the MSB of the extracted field.
- Upper address bits beyond the word index are not masked; any index >= DEPTH is an error.

Test Plan:
- Preload word 4 = 0x823456F0, then issue a signed byte load at 0x10. Expect resp_rdata=0xFFFFFFF0 one cycle after acceptance and resp_err=0. An unsigned byte load at 0x13 returns 0x00000082.
- Signed halfword load at 0x12 → 0xFFFF8234. Unsigned word load at 0x10 → 0x823456F0. Check req_ready=0 during RD.
- Byte store 0x000000AB at 0x11 → mem_we high exactly one cycle, two cycles after acceptance. Word 4 becomes 0x8234ABF0, and resp_valid follows the write edge.
- Word store 0xDEADBEEF at 0x20 → mem_we high the cycle after acceptance with mem_addr=8. A following word load at 0x20 returns 0xDEADBEEF.
- Error cases, each giving resp_err=1 and mem_we never asserted:
  - word load at 0x12 (misaligned);
  - halfword store at 0x11 (misaligned);
  - size 11;
  - word load at 0x338 (index 206).
- Assert reset during RMW → at the next edge the unit is in IDLE, mem_we=0, resp_valid=0, req_ready=1, and word 4 is unchanged. A new load then completes normally.
